// File: rtl/chu_pkg.sv
// Shared encodings and helpers for the message-schedule generator.
package chu_pkg;
  localparam logic CHU_SHA1 = 1'b0;
  localparam logic CHU_MD5  = 1'b1;

  localparam int SHA1_ROUNDS = 80;
  localparam int MD5_ROUNDS  = 64;

  typedef enum logic {IDLE, EMIT} state_t;

  // MD5 message-word index for round t; only t[5:0] is meaningful.
  function automatic logic [3:0] md5_g(input logic [6:0] t);
    logic [6:0] g;
    case (t[5:4])
      2'd0:    g = t;
      2'd1:    g = (t << 2) + t + 7'd1;
      2'd2:    g = (t << 1) + t + 7'd5;
      default: g = (t << 3) - t;
    endcase
    return g[3:0];
  endfunction

  function automatic logic [31:0] rotl1(input logic [31:0] x);
    return {x[30:0], x[31]};
  endfunction
endpackage

// File: rtl/chu_sched_win.sv
// Sixteen-word schedule window: parallel load, or shift toward tap 0 with a new top word.
module chu_sched_win #(
  parameter int WORD_W = 32,
  parameter int NWORDS = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           load,
  input  logic                           shift,
  input  logic [NWORDS-1:0][WORD_W-1:0]  ld_data,
  input  logic [WORD_W-1:0]              shin,
  output logic [NWORDS-1:0][WORD_W-1:0]  taps
);
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        taps <= '0;
    else if (load)  taps <= ld_data;
    else if (shift) taps <= {shin, taps[NWORDS-1:1]};
  end
endmodule

// File: rtl/chu_sched.sv
// Captures one padded block and streams SHA-1 expanded or MD5 permuted schedule words.
module chu_sched
  import chu_pkg::*;
#(
  parameter int WORD_W = 32,
  parameter int NWORDS = 16
) (
  input  logic                           sys_clk,
  input  logic                           sys_reset,
  input  logic [NWORDS-1:0][WORD_W-1:0]  w,
  input  logic [NWORDS-1:0]              w_val,
  input  logic                           alg,
  output logic                           blk_rdy,
  output logic [WORD_W-1:0]              wt,
  output logic [6:0]                     wt_idx,
  output logic                           wt_val,
  input  logic                           wt_rdy,
  output logic                           wt_last,
  output logic                           ovr_err
);
  state_t                          state;
  logic                            alg_q;
  logic [6:0]                      t;
  logic [NWORDS-1:0][WORD_W-1:0]   win;
  logic                            full, cap, beat, shift;
  logic [6:0]                      t_nxt, t_end;
  logic [WORD_W-1:0]               shin, wt_nxt;

  assign full   = &w_val;
  assign cap    = (state == IDLE) && full;
  assign beat   = (state == EMIT) && wt_val && wt_rdy;
  assign shift  = beat && (alg_q == CHU_SHA1);
  assign t_nxt  = t + 7'd1;
  assign t_end  = (alg_q == CHU_MD5) ? 7'(MD5_ROUNDS - 1) : 7'(SHA1_ROUNDS - 1);
  assign wt_idx = t;

  // Shifts at t >= 64 only drain the window; words past 79 are never read.
  assign shin   = (t < 7'd64) ? rotl1(win[13] ^ win[8] ^ win[2] ^ win[0]) : '0;
  // Next word is looked up before the shift lands, so SHA-1 reads tap 1.
  assign wt_nxt = (alg_q == CHU_MD5) ? win[md5_g(t_nxt)] : win[1];

  chu_sched_win #(.WORD_W(WORD_W), .NWORDS(NWORDS)) u_win (
    .clk     (sys_clk),
    .rst     (sys_reset),
    .load    (cap),
    .shift   (shift),
    .ld_data (w),
    .shin    (shin),
    .taps    (win)
  );

  always_ff @(posedge sys_clk or posedge sys_reset) begin
    if (sys_reset) begin
      state   <= IDLE;
      alg_q   <= CHU_SHA1;
      t       <= '0;
      wt      <= '0;
      wt_val  <= 1'b0;
      wt_last <= 1'b0;
      blk_rdy <= 1'b1;
      ovr_err <= 1'b0;
    end else begin
      if ((state == EMIT) && full) ovr_err <= 1'b1;
      case (state)
        IDLE: if (cap) begin
          state   <= EMIT;
          alg_q   <= alg;
          t       <= '0;
          wt      <= w[0];   // round 0 reads word 0 for both algorithms
          wt_val  <= 1'b1;
          wt_last <= 1'b0;
          blk_rdy <= 1'b0;
        end
        EMIT: if (beat) begin
          if (wt_last) begin
            state   <= IDLE;
            t       <= '0;
            wt_val  <= 1'b0;
            wt_last <= 1'b0;
            blk_rdy <= 1'b1;
          end else begin
            t       <= t_nxt;
            wt      <= wt_nxt;
            wt_last <= (t_nxt == t_end);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_chu_sched.sv
// Self-checking bench for chu_sched: known-answer tables, corner sequences, random blocks vs model.
module tb_chu_sched;
  logic              sys_clk = 1'b0;
  logic              sys_reset;
  logic [15:0][31:0] w;
  logic [15:0]       w_val;
  logic              alg, wt_rdy;
  logic              blk_rdy, wt_val, wt_last, ovr_err;
  logic [31:0]       wt;
  logic [6:0]        wt_idx;

  int n_chk = 0;
  int n_fail = 0;

  logic [31:0] blk     [16];
  logic [31:0] exp_w   [80];
  logic [31:0] got_w   [80];
  logic [31:0] abc_ref [80];
  logic        got_last[80];
  int          n_got;

  typedef struct {
    logic        a;
    int          idx;
    logic [31:0] wt;
    logic        last;
    logic        use_wt;
  } vec_t;
  vec_t tbl[9];

  chu_sched dut (
    .sys_clk(sys_clk), .sys_reset(sys_reset), .w(w), .w_val(w_val), .alg(alg),
    .blk_rdy(blk_rdy), .wt(wt), .wt_idx(wt_idx), .wt_val(wt_val), .wt_rdy(wt_rdy),
    .wt_last(wt_last), .ovr_err(ovr_err)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] rl1(input logic [31:0] x);
    return (x << 1) | (x >> 31);
  endfunction

  // Reference schedule straight from the algorithm definitions.
  task automatic build_model(input logic a);
    for (int i = 0; i < 80; i++) exp_w[i] = '0;
    if (a == 1'b0) begin
      for (int i = 0; i < 16; i++) exp_w[i] = blk[i];
      for (int i = 16; i < 80; i++)
        exp_w[i] = rl1(exp_w[i-3] ^ exp_w[i-8] ^ exp_w[i-14] ^ exp_w[i-16]);
    end else begin
      for (int i = 0; i < 64; i++) begin
        int g;
        if (i < 16)      g = i;
        else if (i < 32) g = (5*i + 1) % 16;
        else if (i < 48) g = (3*i + 5) % 16;
        else             g = (7*i) % 16;
        exp_w[i] = blk[g];
      end
    end
  endtask

  task automatic rand_blk();
    for (int i = 0; i < 16; i++) blk[i] = $urandom;
  endtask

  task automatic abc_blk(input logic a);
    for (int i = 0; i < 16; i++) blk[i] = '0;
    if (a == 1'b0) begin blk[0] = 32'h61626380; blk[15] = 32'h00000018; end
    else           begin blk[0] = 32'h80636261; blk[14] = 32'h00000018; end
  endtask

  // Present blk, stream the whole block out and check it. mode: 0 rdy=1, 1 = 1,0,0,1 pattern, 2 random.
  // Entered and left at posedge+1.
  task automatic run_block(input logic a, input int mode, input int ovr_at);
    int          rounds;
    logic        stalled, done, pulsed;
    logic [31:0] h_wt;
    logic [6:0]  h_idx;
    logic        h_last;
    rounds = a ? 64 : 80;
    stalled = 1'b0; done = 1'b0; pulsed = 1'b0;
    h_wt = '0; h_idx = '0; h_last = 1'b0;
    build_model(a);
    for (int i = 0; i < 16; i++) w[i] = blk[i];
    chk("blk_rdy_before_capture", 32'(blk_rdy), 32'd1);
    alg = a; w_val = '1;
    @(posedge sys_clk); #1;
    w_val = '0; alg = ~a;
    chk("first_wt_val", 32'(wt_val), 32'd1);
    chk("first_wt_idx", 32'(wt_idx), 32'd0);
    chk("blk_rdy_after_capture", 32'(blk_rdy), 32'd0);
    n_got = 0;
    for (int cyc = 0; cyc < 400 && !done; cyc++) begin
      chk("wt_val_held", 32'(wt_val), 32'd1);
      if (stalled) begin
        chk("stall_wt", wt, h_wt);
        chk("stall_idx", 32'(wt_idx), 32'(h_idx));
        chk("stall_last", 32'(wt_last), 32'(h_last));
      end
      if (ovr_at >= 0 && !pulsed && int'(wt_idx) == ovr_at) begin
        for (int i = 0; i < 16; i++) w[i] = ~blk[i];
        w_val = '1; pulsed = 1'b1;
      end else w_val = '0;
      case (mode)
        0:       wt_rdy = 1'b1;
        1:       wt_rdy = (cyc % 4 == 0) || (cyc % 4 == 3);
        default: wt_rdy = 1'($urandom_range(0, 1));
      endcase
      if (wt_val && wt_rdy) begin
        if (n_got < 80) begin got_w[n_got] = wt; got_last[n_got] = wt_last; end
        chk("beat_idx", 32'(wt_idx), 32'(n_got));
        n_got++;
        if (wt_last) done = 1'b1;
      end
      stalled = wt_val && !wt_rdy;
      h_wt = wt; h_idx = wt_idx; h_last = wt_last;
      @(posedge sys_clk); #1;
    end
    w_val = '0;
    chk("block_completed", 32'(done), 32'd1);
    chk("word_count", 32'(n_got), 32'(rounds));
    chk("blk_rdy_after_last", 32'(blk_rdy), 32'd1);
    chk("wt_val_after_last", 32'(wt_val), 32'd0);
    for (int i = 0; i < rounds && i < n_got; i++) begin
      chk($sformatf("word_%0d", i), got_w[i], exp_w[i]);
      chk($sformatf("last_%0d", i), 32'(got_last[i]), 32'(i == rounds - 1));
    end
  endtask

  task automatic apply_table(input logic a);
    foreach (tbl[k]) if (tbl[k].a == a) begin
      if (tbl[k].use_wt) chk($sformatf("tbl_wt_%0d_%0d", a, tbl[k].idx), got_w[tbl[k].idx], tbl[k].wt);
      chk($sformatf("tbl_last_%0d_%0d", a, tbl[k].idx), 32'(got_last[tbl[k].idx]), 32'(tbl[k].last));
    end
  endtask

  initial begin
    tbl[0] = '{1'b0, 0,  32'h61626380, 1'b0, 1'b1};
    tbl[1] = '{1'b0, 16, 32'hC2C4C700, 1'b0, 1'b1};
    tbl[2] = '{1'b0, 17, 32'h00000000, 1'b0, 1'b1};
    tbl[3] = '{1'b0, 18, 32'h00000030, 1'b0, 1'b1};
    tbl[4] = '{1'b0, 79, 32'h00000000, 1'b1, 1'b0};
    tbl[5] = '{1'b1, 0,  32'h80636261, 1'b0, 1'b1};
    tbl[6] = '{1'b1, 14, 32'h00000018, 1'b0, 1'b1};
    tbl[7] = '{1'b1, 19, 32'h80636261, 1'b0, 1'b1};
    tbl[8] = '{1'b1, 63, 32'h00000000, 1'b1, 1'b0};

    sys_reset = 1'b1; w = '0; w_val = '0; alg = 1'b0; wt_rdy = 1'b0;
    #12;
    chk("rst_blk_rdy", 32'(blk_rdy), 32'd1);
    chk("rst_wt_val", 32'(wt_val), 32'd0);
    chk("rst_wt", wt, 32'd0);
    chk("rst_wt_idx", 32'(wt_idx), 32'd0);
    chk("rst_wt_last", 32'(wt_last), 32'd0);
    chk("rst_ovr_err", 32'(ovr_err), 32'd0);
    @(posedge sys_clk); #1;
    sys_reset = 1'b0;

    // Known-answer blocks
    abc_blk(1'b0); run_block(1'b0, 0, -1); apply_table(1'b0);
    for (int i = 0; i < 80; i++) abc_ref[i] = got_w[i];
    abc_blk(1'b1); run_block(1'b1, 0, -1); apply_table(1'b1);

    // Partial valid in IDLE never captures
    for (int k = 0; k < 8; k++) begin
      logic [15:0] m;
      m = '1;
      m[(k == 0) ? 15 : $urandom_range(0, 15)] = 1'b0;
      w_val = m;
      @(posedge sys_clk); #1;
      chk("partial_blk_rdy", 32'(blk_rdy), 32'd1);
      chk("partial_wt_val", 32'(wt_val), 32'd0);
    end
    w_val = '0;

    // Backpressure: same stream as the unstalled run
    abc_blk(1'b0); run_block(1'b0, 1, -1);
    for (int i = 0; i < 80; i++) chk($sformatf("bp_word_%0d", i), got_w[i], abc_ref[i]);

    // Overrun at t = 10
    chk("ovr_err_clear", 32'(ovr_err), 32'd0);
    abc_blk(1'b0); run_block(1'b0, 0, 10);
    chk("ovr_err_set", 32'(ovr_err), 32'd1);
    @(posedge sys_clk); #1;
    chk("ovr_err_sticky", 32'(ovr_err), 32'd1);

    // Reset at t = 40
    rand_blk();
    for (int i = 0; i < 16; i++) w[i] = blk[i];
    alg = 1'b0; w_val = '1; wt_rdy = 1'b1;
    @(posedge sys_clk); #1;
    w_val = '0;
    begin
      bit hit;
      hit = 1'b0;
      for (int c = 0; c < 200 && !hit; c++) begin
        if (wt_idx == 7'd40) hit = 1'b1;
        else begin @(posedge sys_clk); #1; end
      end
      chk("reached_t40", 32'(hit), 32'd1);
    end
    #2 sys_reset = 1'b1;
    #1;
    chk("midrst_wt_val", 32'(wt_val), 32'd0);
    chk("midrst_blk_rdy", 32'(blk_rdy), 32'd1);
    chk("midrst_ovr_err", 32'(ovr_err), 32'd0);
    chk("midrst_wt_idx", 32'(wt_idx), 32'd0);
    @(posedge sys_clk); #1;
    sys_reset = 1'b0;
    rand_blk(); run_block(1'b1, 0, -1);

    // Back-to-back: second block presented on the cycle blk_rdy returns
    rand_blk(); run_block(1'b0, 0, -1);
    rand_blk(); run_block(1'b1, 2, -1);
    chk("b2b_no_ovr", 32'(ovr_err), 32'd0);

    // Random blocks, algorithms and consumer stalls
    for (int r = 0; r < 6; r++) begin
      rand_blk();
      run_block(1'($urandom_range(0, 1)), 2, -1);
    end
    chk("final_no_ovr", 32'(ovr_err), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
